mem_stage: RTL

- Memory-access pipeline stage of the 16-bit CPU. Sits between the execute stage and write-back.
- Consumes the execute stage's registered outputs: mem_ir, reg_C, dw and smdr1.
- Performs LOAD/STORE through a req/ack data-memory port and produces wb_ir/reg_C1 for write-back.
- Drives mem_stall to freeze upstream stages while an access is outstanding; a watchdog bounds every access.

---
 rtl/mem_stage.sv | 116 +++++++++++
 1 files changed

// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage; issues LOAD/STORE on a req/ack port,
// stalls upstream while an access is outstanding and aborts it after MAX_WAIT cycles.
module mem_stage #(
    parameter int          MAX_WAIT = 15,
    parameter logic [15:0] NOP_IR   = 16'h0000,
    parameter logic        EXEC     = 1'b1,
    parameter logic [4:0]  LOAD_OP  = 5'b10001
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        state,
    input  logic [15:0] mem_ir,
    input  logic [15:0] reg_C,
    input  logic        dw,
    input  logic [15:0] smdr1,
    output logic        d_req,
    output logic        d_we,
    output logic [15:0] d_addr,
    output logic [15:0] d_dout,
    input  logic        d_ack,
    input  logic [15:0] d_din,
    output logic [15:0] wb_ir,
    output logic [15:0] reg_C1,
    output logic        mem_stall,
    output logic        bus_err
);
    localparam int CW = $clog2(MAX_WAIT + 1);

    typedef enum logic {IDLE, ACCESS} st_t;

    st_t           st_q, st_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          req_q, req_d, we_q, we_d, err_q, err_d, ld_q, ld_d;
    logic [15:0]   addr_q, addr_d, dout_q, dout_d, wb_q, wb_d, c1_q, c1_d, ir_q, ir_d;
    logic          memop, timeout, is_load;

    assign is_load   = mem_ir[15:11] == LOAD_OP;
    assign memop     = (state == EXEC) && (is_load || dw);
    assign timeout   = cnt_q == CW'(MAX_WAIT - 1);
    assign mem_stall = (st_q == IDLE && memop) || (st_q == ACCESS && !d_ack && !timeout);

    always_comb begin
        st_d   = st_q;
        cnt_d  = cnt_q;
        req_d  = req_q;
        we_d   = we_q;
        addr_d = addr_q;
        dout_d = dout_q;
        wb_d   = wb_q;
        c1_d   = c1_q;
        err_d  = err_q;
        ir_d   = ir_q;
        ld_d   = ld_q;
        if (st_q == IDLE) begin
            if (memop) begin
                req_d  = 1'b1;
                we_d   = dw;
                addr_d = reg_C;
                dout_d = smdr1;
                ir_d   = mem_ir;
                ld_d   = is_load;
                wb_d   = NOP_IR;
                cnt_d  = '0;
                st_d   = ACCESS;
            end else if (state == EXEC) begin
                wb_d = mem_ir;
                c1_d = reg_C;
            end
        end else if (d_ack || timeout) begin
            // an ack in the timeout cycle still completes the access cleanly
            req_d = 1'b0;
            wb_d  = ir_q;
            c1_d  = ld_q ? (d_ack ? d_din : 16'h0000) : addr_q;
            err_d = err_q | !d_ack;
            st_d  = IDLE;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            st_q   <= IDLE;
            cnt_q  <= '0;
            req_q  <= 1'b0;
            we_q   <= 1'b0;
            addr_q <= '0;
            dout_q <= '0;
            wb_q   <= '0;
            c1_q   <= '0;
            err_q  <= 1'b0;
            ir_q   <= '0;
            ld_q   <= 1'b0;
        end else begin
            st_q   <= st_d;
            cnt_q  <= cnt_d;
            req_q  <= req_d;
            we_q   <= we_d;
            addr_q <= addr_d;
            dout_q <= dout_d;
            wb_q   <= wb_d;
            c1_q   <= c1_d;
            err_q  <= err_d;
            ir_q   <= ir_d;
            ld_q   <= ld_d;
        end
    end

    assign d_req   = req_q;
    assign d_we    = we_q;
    assign d_addr  = addr_q;
    assign d_dout  = dout_q;
    assign wb_ir   = wb_q;
    assign reg_C1  = c1_q;
    assign bus_err = err_q;
endmodule
